// File: rtl/frequency_adj_pkg.sv
// Shared defaults and step encoding for the front-panel frequency scale selector.
package frequency_adj_pkg;

  localparam int WIDTH           = 6;
  localparam int SCALE_INIT      = 0;
  localparam int SCALE_MIN       = 0;
  localparam int SCALE_MAX       = 63;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN
  } step_e;

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes and debounces one asynchronous push-button.
// Produces a single-cycle pulse when the debounced level rises.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   d;
  logic                   d_next;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      d    <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      d    <= d_next;
      cnt  <= cnt_next;
    end
  end

  // Count runs only while the sample disagrees with d; any agreeing sample
  // restarts it. The pulse is taken from d_next so the scale register can
  // react on the same edge at which d rises.
  always_comb begin
    d_next   = d;
    cnt_next = '0;
    if (synced != d) begin
      if (cnt == CNT_LAST) begin
        d_next = synced;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  assign rise = d_next & ~d;

endmodule

// File: rtl/frequency_adj.sv
// Front-panel frequency scale selector: Plus/Minus buttons step a
// saturating unsigned Scale register.
module frequency_adj #(
  parameter int WIDTH           = frequency_adj_pkg::WIDTH,
  parameter int SCALE_INIT      = frequency_adj_pkg::SCALE_INIT,
  parameter int SCALE_MIN       = frequency_adj_pkg::SCALE_MIN,
  parameter int SCALE_MAX       = frequency_adj_pkg::SCALE_MAX,
  parameter int SYNC_STAGES     = frequency_adj_pkg::SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = frequency_adj_pkg::DEBOUNCE_CYCLES
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             Plus,
  input  logic             Minus,
  output logic [WIDTH-1:0] Scale
);

  import frequency_adj_pkg::*;

  logic  plus_rise;
  logic  minus_rise;
  step_e step;

  button_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_plus (
    .clk  (sysclk),
    .rst_n(rst_n),
    .btn  (Plus),
    .rise (plus_rise)
  );

  button_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_minus (
    .clk  (sysclk),
    .rst_n(rst_n),
    .btn  (Minus),
    .rise (minus_rise)
  );

  // Simultaneous presses cancel out.
  always_comb begin
    step = STEP_HOLD;
    if (plus_rise && !minus_rise) begin
      step = STEP_UP;
    end else if (minus_rise && !plus_rise) begin
      step = STEP_DOWN;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      Scale <= WIDTH'(SCALE_INIT);
    end else begin
      case (step)
        STEP_UP:   if (Scale < WIDTH'(SCALE_MAX)) Scale <= Scale + WIDTH'(1);
        STEP_DOWN: if (Scale > WIDTH'(SCALE_MIN)) Scale <= Scale - WIDTH'(1);
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_adj.sv
// Directed bench for frequency_adj: latency, saturation, glitch rejection,
// hold behaviour, simultaneous presses and reset mid-press.
`timescale 1ns/1ps
module tb_frequency_adj;

  logic       sysclk;
  logic       rst_n;
  logic       Plus;
  logic       Minus;
  logic [5:0] Scale;

  int compared   = 0;
  int mismatched = 0;

  frequency_adj dut (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .Plus  (Plus),
    .Minus (Minus),
    .Scale (Scale)
  );

  initial sysclk = 1'b0;
  always #10 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: Scale=%0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the chosen buttons for width_ns starting 3 ns after an edge,
  // then leave enough idle cycles for the debounced release.
  task automatic press(input bit p, input bit m, input int unsigned width_ns);
    @(posedge sysclk);
    #3;
    Plus  = p;
    Minus = m;
    #(width_ns);
    Plus  = 1'b0;
    Minus = 1'b0;
    repeat (12) @(posedge sysclk);
    #1;
  endtask

  initial begin
    Plus  = 1'b0;
    Minus = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_async", Scale, 6'd0);
    repeat (3) @(posedge sysclk);
    #1;
    check("reset_held", Scale, 6'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;
    check("idle", Scale, 6'd0);

    // First press: exact latency, 111 ns wide.
    @(posedge sysclk);
    #3;
    Plus = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge sysclk);
      #1;
      check("plus_latency_before", Scale, 6'd0);
    end
    #13;
    Plus = 1'b0;
    @(posedge sysclk);
    #1;
    check("plus_latency_k5", Scale, 6'd1);
    repeat (12) @(posedge sysclk);
    #1;
    check("plus_first_settled", Scale, 6'd1);

    press(1'b1, 1'b0, 121);
    check("plus_second", Scale, 6'd2);

    press(1'b0, 1'b1, 131);
    check("minus_first", Scale, 6'd1);
    press(1'b0, 1'b1, 141);
    check("minus_second", Scale, 6'd0);
    press(1'b0, 1'b1, 120);
    check("minus_sat_min", Scale, 6'd0);

    // Hold Plus for 2 us: one step only.
    @(posedge sysclk);
    #3;
    Plus = 1'b1;
    repeat (50) @(posedge sysclk);
    #1;
    check("hold_mid", Scale, 6'd1);
    #999;
    Plus = 1'b0;
    repeat (12) @(posedge sysclk);
    #1;
    check("hold_released", Scale, 6'd1);

    press(1'b1, 1'b0, 30);
    check("glitch_ignored", Scale, 6'd1);

    for (int unsigned n = 0; n < 62; n++) press(1'b1, 1'b0, 120);
    check("reach_max", Scale, 6'd63);
    press(1'b1, 1'b0, 120);
    check("plus_sat_max", Scale, 6'd63);
    press(1'b1, 1'b1, 120);
    check("both_at_max", Scale, 6'd63);
    press(1'b0, 1'b1, 120);
    check("minus_from_max", Scale, 6'd62);
    press(1'b1, 1'b1, 120);
    check("both_mid", Scale, 6'd62);

    // Reset mid-press at Scale = 5.
    rst_n = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    check("reset_again", Scale, 6'd0);
    rst_n = 1'b1;
    for (int unsigned n = 0; n < 5; n++) press(1'b1, 1'b0, 120);
    check("count_to_5", Scale, 6'd5);
    @(posedge sysclk);
    #3;
    Plus = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    check("pending_press", Scale, 6'd5);
    rst_n = 1'b0;
    #1;
    check("reset_mid_press", Scale, 6'd0);
    repeat (2) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge sysclk);
      #1;
      check("held_after_reset_before", Scale, 6'd0);
    end
    @(posedge sysclk);
    #1;
    check("held_after_reset_step", Scale, 6'd1);
    repeat (20) @(posedge sysclk);
    #1;
    Plus = 1'b0;
    repeat (12) @(posedge sysclk);
    #1;
    check("held_after_reset_final", Scale, 6'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
